layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Time-multiplexes one shared 8x8 signed MAC and saturating clamp across NUM_NEURONS neurons of one fully-connected layer.
- Buffers an input activation vector, then fetches weights from an external combinational weight ROM and accumulates one product per cycle.
- Emits one clamped int8 result per neuron over a valid/ready stream.
- Sits between the previous layer's output stream and the next layer's input stream.

Parameters:
- NUM_INPUTS, 8, activations per vector and MAC steps per neuron (>=2).
- NUM_NEURONS, 4, neurons in the layer (>=1).
- ACC_W, 20, accumulator width. Must be >= 16+clog2(NUM_INPUTS).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  activation valid.
- in_ready  output  1  block accepts an activation.
- in_data  input  8  signed activation.
- weight_addr  output  clog2(NUM_INPUTS*NUM_NEURONS)  ROM address, equal to neuron*NUM_INPUTS+idx.
- weight_data  input  8  signed weight, valid in the same cycle as weight_addr (combinational ROM).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8  signed clamped neuron result.
- out_index  output  clog2(NUM_NEURONS)  neuron index of out_data.
- busy  output  1  high in MAC or EMIT.
- layer_done  output  1  one-cycle pulse on the last neuron's output handshake.

Behaviour:
- Reset: one clock with rst_n low, sampled on the rising edge, synchronous active-low.
  - State goes to LOAD; load pointer, idx, neuron and acc go to 0.
  - out_valid=0, layer_done=0, busy=0, weight_addr=0, out_data=0, out_index=0.
  - in_ready is gated by rst_n, so it is 0 while rst_n is low.
- State machine has three states: LOAD, MAC, EMIT.
- LOAD:
  - in_ready=1.
  - On each in_valid&&in_ready, write in_data to act[ptr] and increment ptr.
  - On the handshake with ptr==NUM_INPUTS-1, go to MAC with ptr=0, idx=0, neuron=0, acc=0.
- MAC:
  - in_ready=0; weight_addr = neuron*NUM_INPUTS+idx.
  - Every cycle, acc <= acc + sext(act[idx]*weight_data). The product is a 16-bit signed value sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W and is never saturated internally.
  - At idx==NUM_INPUTS-1, include the final product and go to EMIT. Otherwise idx++.
  - MAC takes exactly NUM_INPUTS cycles per neuron.
- EMIT:
  - out_valid=1; out_index=neuron; out_data=clamp(acc).
  - out_data and out_index are registered or derived from held state, and stay stable while out_valid && !out_ready.
  - On out_valid&&out_ready:
    - If neuron<NUM_NEURONS-1: neuron++, idx=0, acc=0, go to MAC (the next cycle is MAC step 0).
    - Otherwise: pulse layer_done for that same cycle and go to LOAD.
- clamp (signed):
  - acc >= 127 gives 127.
  - acc <= -128 gives -128.
  - Otherwise acc[7:0].
- Per-neuron latency is NUM_INPUTS MAC cycles plus at least 1 EMIT cycle. With out_ready tied high, one layer takes NUM_INPUTS + NUM_NEURONS*(NUM_INPUTS+1) cycles.
- Boundary conditions:
  - in_valid outside LOAD is ignored and no data is captured.
  - out_ready outside EMIT has no effect.
  - Backpressure in EMIT freezes idx, neuron, acc and weight_addr.
  - Reset in any state aborts the layer. Partial activations and acc are discarded, and no output or layer_done is produced.
  - Activation buffer contents persist but are fully overwritten by the next LOAD.

Decomposition:
- Shared package holds:
  - the state enum (LOAD/MAC/EMIT);
  - the saturation constants SAT_MAX=127 and SAT_MIN=-128;
  - a width helper function for weight_addr.
- One sub-module: acc_clamp.
  - Parameter IN_WIDTH=ACC_W.
  - Purely combinational saturation of a signed IN_WIDTH value to signed 8 bits, per the clamp rule above.
  - Instantiated once on acc.
- MAC multiply/add stays inline.

Test Plan:
- All 8 activations=1, all weights=1, out_ready=1: outputs (index 0..3, data 8). layer_done pulses with the index-3 handshake. in_ready returns to 1 on the next cycle.
- Activations all 127, weights all 127: acc=129032, out_data=127 for every neuron.
- Activations all 127, weights all -128: acc=-130048, out_data=-128.
- Activations 1..8:
  - Neuron-0 weights all 2 gives 72.
  - Neuron-2 weights all -1 gives -36.
  - Neuron-1 weights {10,0,...} gives 10.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT of neuron 1.
  - out_valid stays 1; out_data and out_index are stable; weight_addr is frozen; in_ready=0.
  - Pulse in_valid=1 during the stall: it is ignored.
  - The layer result is unchanged afterwards.
- Reset mid-MAC (3rd MAC cycle of neuron 1):
  - Cycle after the rst_n-low edge: out_valid=0, busy=0, in_ready=0.
  - After rst_n goes high, a fresh layer of activations 1/weights 1 produces exactly 4 outputs of 8, with no residue.

Source files
------------

// File: rtl/layer_sequencer_pkg.sv
// Purpose: shared types and constants for the layer sequencer and its clamp.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, int8 saturation bounds, address-width helper.
package layer_sequencer_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  // Bit width needed to index 'depth' entries; never below 1 so a
  // single-entry space still gets a legal one-bit port.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/layer_sequencer_acc_clamp.sv
// Purpose: saturate a signed accumulator value to signed int8.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of din).
// Ports: din  - signed IN_WIDTH accumulator value
//        dout - signed 8-bit result, clamped to [SAT_MIN, SAT_MAX]
module acc_clamp
  import layer_sequencer_pkg::*;
#(
  parameter int IN_WIDTH = 20
) (
  input  logic signed [IN_WIDTH-1:0] din,
  output logic signed [7:0]          dout
);

  localparam logic signed [IN_WIDTH-1:0] HI = IN_WIDTH'(SAT_MAX);
  localparam logic signed [IN_WIDTH-1:0] LO = IN_WIDTH'(SAT_MIN);

  always_comb begin
    dout = din[7:0];
    if (din >= HI) begin
      dout = 8'(SAT_MAX);
    end else if (din <= LO) begin
      dout = 8'(SAT_MIN);
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Purpose: one fully-connected layer on a single shared 8x8 MAC + int8 clamp.
// Latency: NUM_INPUTS load beats, then NUM_INPUTS MAC cycles + >=1 emit cycle per neuron.
// Backpressure: in_ready only in LOAD; out_ready low in EMIT freezes all datapath state.
// Ports: clk/rst_n (sync active-low); in_valid/in_ready/in_data activation stream;
//        weight_addr/weight_data combinational ROM; out_valid/out_ready/out_data/
//        out_index result stream; busy (MAC or EMIT); layer_done (last result handshake).
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter  int NUM_INPUTS  = 8,
  parameter  int NUM_NEURONS = 4,
  parameter  int ACC_W       = 20,
  localparam int AW          = addr_w(NUM_INPUTS * NUM_NEURONS),
  localparam int IW          = addr_w(NUM_INPUTS),
  localparam int NW          = addr_w(NUM_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [7:0]    in_data,
  output logic        [AW-1:0] weight_addr,
  input  logic signed [7:0]    weight_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [7:0]    out_data,
  output logic        [NW-1:0] out_index,
  output logic                 busy,
  output logic                 layer_done
);

  localparam logic [IW-1:0] LAST_IN = IW'(NUM_INPUTS - 1);
  localparam logic [NW-1:0] LAST_N  = NW'(NUM_NEURONS - 1);

  state_t                  state, state_nxt;
  logic        [IW-1:0]    ptr;
  logic        [IW-1:0]    idx;
  logic        [NW-1:0]    neuron;
  logic signed [ACC_W-1:0] acc;
  logic signed [7:0]       act [NUM_INPUTS];
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic        [AW-1:0]    addr_cur;

  assign prod     = act[idx] * weight_data;
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  assign addr_cur = AW'(neuron) * AW'(NUM_INPUTS) + AW'(idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    layer_done  = 1'b0;
    weight_addr = '0;
    case (state)
      LOAD: begin
        // Gated by rst_n so no beat is acknowledged during reset.
        in_ready = rst_n;
        if (in_valid && rst_n && ptr == LAST_IN) state_nxt = MAC;
      end
      MAC: begin
        busy        = 1'b1;
        weight_addr = addr_cur;
        if (idx == LAST_IN) state_nxt = EMIT;
      end
      EMIT: begin
        busy        = 1'b1;
        out_valid   = 1'b1;
        // idx/neuron are held, so the address stays frozen during a stall.
        weight_addr = addr_cur;
        if (out_ready) begin
          if (neuron == LAST_N) begin
            layer_done = 1'b1;
            state_nxt  = LOAD;
          end else begin
            state_nxt  = MAC;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr    <= '0;
      idx    <= '0;
      neuron <= '0;
      acc    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (ptr == LAST_IN) begin
              ptr    <= '0;
              idx    <= '0;
              neuron <= '0;
              acc    <= '0;
            end else begin
              ptr <= ptr + IW'(1);
            end
          end
        end
        MAC: begin
          // Wraps modulo 2^ACC_W; saturation happens only at the output.
          acc <= acc + prod_ext;
          if (idx != LAST_IN) idx <= idx + IW'(1);
        end
        EMIT: begin
          if (out_ready) begin
            idx <= '0;
            acc <= '0;
            if (neuron == LAST_N) neuron <= '0;
            else                  neuron <= neuron + NW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Activation buffer needs no reset: every LOAD overwrites all entries
  // before the MAC phase reads any of them.
  always_ff @(posedge clk) begin
    if (rst_n && state == LOAD && in_valid) act[ptr] <= in_data;
  end

  acc_clamp #(.IN_WIDTH(ACC_W)) u_clamp (
    .din  (acc),
    .dout (out_data)
  );

  assign out_index = neuron;

endmodule

// File: tb/tb_layer_sequencer.sv
// Purpose: scoreboard bench for layer_sequencer with directed layers.
// Latency: n/a.
// Backpressure: bench drives out_ready, including a stall in neuron 1's emit.
module tb_layer_sequencer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic        [4:0] weight_addr;
  logic signed [7:0] weight_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic        [1:0] out_index;
  logic              busy;
  logic              layer_done;

  logic signed [7:0] rom  [32];
  logic signed [7:0] acts [8];
  int                expv [4];

  typedef struct {
    int idx;
    int data;
    int last;
  } exp_t;
  exp_t sb [$];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign weight_data = rom[weight_addr];

  layer_sequencer #(.NUM_INPUTS(8), .NUM_NEURONS(4), .ACC_W(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .busy        (busy),
    .layer_done  (layer_done)
  );

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got index %0d data %0d, expected no output",
                 out_index, out_data);
      end else begin
        e = sb.pop_front();
        check("out_index", out_index, e.idx);
        check("out_data", out_data, e.data);
        check("layer_done_hs", layer_done, e.last);
      end
    end else if (layer_done === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL stray_layer_done: got 1, expected 0");
    end
  end

  task automatic push_layer(input int upto);
    for (int n = 0; n < upto; n++) sb.push_back('{n, expv[n], (n == 3) ? 1 : 0});
  endtask

  task automatic load_acts();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = acts[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    check(name, sb.size(), 0);
    check({name, "_in_ready"}, in_ready, 1);
    check({name, "_busy"}, busy, 0);
  endtask

  task automatic fill_uniform(input int a, input int w);
    for (int i = 0; i < 8; i++)  acts[i] = 8'(a);
    for (int i = 0; i < 32; i++) rom[i]  = 8'(w);
  endtask

  task automatic fill_ramp_mixed();
    for (int i = 0; i < 8; i++) acts[i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) begin
      rom[i]      = 8'sd2;
      rom[8 + i]  = (i == 0) ? 8'sd10 : 8'sd0;
      rom[16 + i] = -8'sd1;
      rom[24 + i] = (i % 2 == 0) ? 8'sd1 : -8'sd1;
    end
    expv = '{72, 10, -36, -4};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    fill_uniform(1, 1);

    // Reset values while rst_n is still low.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_busy", busy, 0);
    check("rst_weight_addr", weight_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // All ones: 8 per neuron.
    expv = '{8, 8, 8, 8};
    push_layer(4); load_acts(); drain("ones");

    // Positive saturation: 8*127*127 = 129032.
    fill_uniform(127, 127);
    expv = '{127, 127, 127, 127};
    push_layer(4); load_acts(); drain("sat_pos");

    // Negative saturation: 8*127*-128 = -130048.
    fill_uniform(127, -128);
    expv = '{-128, -128, -128, -128};
    push_layer(4); load_acts(); drain("sat_neg");

    // Ramp activations with distinct per-neuron weights.
    fill_ramp_mixed();
    push_layer(4); load_acts(); drain("ramp");

    // Clamp edges: 128 -> 127, exactly 127, exactly -128, -129 -> -128.
    for (int i = 0; i < 32; i++) rom[i] = 8'sd0;
    rom[7]  = 8'sd16;
    rom[8]  = 8'sd127;
    rom[16] = -8'sd128;
    rom[24] = -8'sd1;
    rom[31] = -8'sd16;
    expv = '{127, 127, -128, -128};
    push_layer(4); load_acts(); drain("edges");

    // Backpressure in neuron 1's emit with a stray in_valid during the stall.
    fill_ramp_mixed();
    push_layer(4); load_acts();
    n = 0;
    while (!(out_valid === 1'b1 && out_index == 2'd1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reached", n < 200, 1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) begin in_valid = 1'b1; in_data = 8'sd99; end
      if (c == 3) in_valid = 1'b0;
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 10);
      check("bp_out_index", out_index, 1);
      check("bp_weight_addr", weight_addr, 15);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("bp");

    // Reset on the 3rd MAC cycle of neuron 1 (address 10); only neuron 0 emits.
    fill_uniform(1, 1);
    expv = '{8, 8, 8, 8};
    push_layer(1); load_acts();
    n = 0;
    while (!(busy === 1'b1 && out_valid === 1'b0 && weight_addr == 5'd10) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_mid_reached", n < 200, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_weight_addr", weight_addr, 0);
    check("rst_mid_sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fresh layer after the abort: exactly four results of 8.
    push_layer(4); load_acts(); drain("after_rst");

    repeat (5) @(posedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
